// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline control logic.
package core_pkg;

  localparam int unsigned REG_IDX_W    = 3;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } hz_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and load-pending bits, with sticky
// over/underflow detection and an all-clear summary.
module reg_scoreboard #(
  parameter  int unsigned NUM_REGS = 8,
  parameter  int unsigned CNT_W    = 2,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_valid_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic             inc_ld_i,
  input  logic             dec_valid_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] rs_idx_i,
  input  logic [IDX_W-1:0] rt_idx_i,
  output logic             ldp_rs_o,
  output logic             ldp_rt_o,
  output logic             all_clear_o,
  output logic             err_o
);

  logic [CNT_W-1:0]    pend_q [NUM_REGS];
  logic [CNT_W-1:0]    pend_d [NUM_REGS];
  logic [NUM_REGS-1:0] ldp_q, ldp_d;
  logic [NUM_REGS-1:0] inc_hit, dec_hit;
  logic                err_q, err_d;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    ldp_d   = '0;
    err_d   = err_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc_hit[r] = inc_valid_i && (inc_idx_i == IDX_W'(r));
      dec_hit[r] = dec_valid_i && (dec_idx_i == IDX_W'(r));
      pend_d[r]  = pend_q[r];
      // Simultaneous issue and retire on one register cancel out.
      if (inc_hit[r] && !dec_hit[r]) begin
        if (pend_q[r] == '1) err_d = 1'b1;
        else                 pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (pend_q[r] == '0) err_d = 1'b1;
        else                 pend_d[r] = pend_q[r] - 1'b1;
      end
      ldp_d[r] = (pend_d[r] == '0) ? 1'b0 : (ldp_q[r] | (inc_hit[r] & inc_ld_i));
    end
  end

  always_comb begin
    all_clear_o = 1'b1;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (pend_q[r] != '0) all_clear_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      ldp_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      ldp_q <= ldp_d;
      err_q <= err_d;
    end
  end

  assign ldp_rs_o = ldp_q[rs_idx_i];
  assign ldp_rt_o = ldp_q[rt_idx_i];
  assign err_o    = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stalls, taken-branch flush and HALT drain
// sequencing for the 5-stage core.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_p1,
  input  logic [REG_IDX_W-1:0] rs_idix_p1,
  input  logic                 rs_used_p1,
  input  logic [REG_IDX_W-1:0] rt_idix_p1,
  input  logic                 rt_used_p1,
  input  logic [REG_IDX_W-1:0] dest_reg_idix_p1,
  input  logic                 reg_write_valid_idix_p1,
  input  logic                 ld_idix_p1,
  input  logic                 halt_idif_p1,
  input  logic                 branch_taken_ixif_p1,
  input  logic [REG_IDX_W-1:0] dest_reg_index_memwb_p1,
  input  logic                 dest_reg_write_valid_memwb_p1,
  output logic                 stall_if_p1,
  output logic                 stall_id_p1,
  output logic                 bubble_ix_p1,
  output logic                 flush_id_p1,
  output logic                 halt_p1,
  output logic                 sb_err_p1
);

  hz_state_t  state_q;
  logic [1:0] drain_cnt_q;
  logic       halt_q;
  logic       run, hazard, flush, stall, issue, inc_valid;
  logic       ldp_rs, ldp_rt, all_clear;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .inc_valid_i (inc_valid),
    .inc_idx_i   (dest_reg_idix_p1),
    .inc_ld_i    (ld_idix_p1),
    .dec_valid_i (dest_reg_write_valid_memwb_p1),
    .dec_idx_i   (dest_reg_index_memwb_p1),
    .rs_idx_i    (rs_idix_p1),
    .rt_idx_i    (rt_idix_p1),
    .ldp_rs_o    (ldp_rs),
    .ldp_rt_o    (ldp_rt),
    .all_clear_o (all_clear),
    .err_o       (sb_err_p1)
  );

  // Branches are ignored outside RUN: nothing older than HALT can redirect.
  always_comb begin
    run       = (state_q == RUN);
    hazard    = id_valid_p1 && ((rs_used_p1 && ldp_rs) || (rt_used_p1 && ldp_rt));
    flush     = run && branch_taken_ixif_p1;
    stall     = run ? (hazard && !flush) : 1'b1;
    issue     = id_valid_p1 && !stall && !flush && run;
    inc_valid = issue && reg_write_valid_idix_p1 && !halt_idif_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue && halt_idif_p1) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (all_clear) begin
            if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end
        HALTED:  halt_q  <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

  assign stall_if_p1  = stall;
  assign stall_id_p1  = stall;
  assign bubble_ix_p1 = stall;
  assign flush_id_p1  = flush;
  assign halt_p1      = halt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, rs_used = 1'b0, rt_used = 1'b0;
  logic [2:0] rs = '0, rt = '0, dest = '0, wb_idx = '0;
  logic       wr = 1'b0, ld = 1'b0, hlt = 1'b0, br = 1'b0, wb_v = 1'b0;
  logic       stall_if, stall_id, bubble_ix, flush_id, halt, sb_err;

  typedef struct {
    string nm;
    logic  s, f, h, e;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_REGS(8), .CNT_W(2)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .id_valid_p1                   (id_valid),
    .rs_idix_p1                    (rs),
    .rs_used_p1                    (rs_used),
    .rt_idix_p1                    (rt),
    .rt_used_p1                    (rt_used),
    .dest_reg_idix_p1              (dest),
    .reg_write_valid_idix_p1       (wr),
    .ld_idix_p1                    (ld),
    .halt_idif_p1                  (hlt),
    .branch_taken_ixif_p1          (br),
    .dest_reg_index_memwb_p1       (wb_idx),
    .dest_reg_write_valid_memwb_p1 (wb_v),
    .stall_if_p1                   (stall_if),
    .stall_id_p1                   (stall_id),
    .bubble_ix_p1                  (bubble_ix),
    .flush_id_p1                   (flush_id),
    .halt_p1                       (halt),
    .sb_err_p1                     (sb_err)
  );

  task automatic chk(input string nm, input string sig, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %b exp %b", nm, sig, got, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "stall_if",  stall_if,  e.s);
        chk(e.nm, "stall_id",  stall_id,  e.s);
        chk(e.nm, "bubble_ix", bubble_ix, e.s);
        chk(e.nm, "flush_id",  flush_id,  e.f);
        chk(e.nm, "halt",      halt,      e.h);
        chk(e.nm, "sb_err",    sb_err,    e.e);
      end
    end
  end

  task automatic step(input string nm,
                      input logic v, input logic [2:0] a, input logic au,
                      input logic [2:0] b, input logic bu,
                      input logic [2:0] d, input logic w, input logic l,
                      input logic h, input logic bt,
                      input logic [2:0] wi, input logic wv,
                      input logic es, input logic ef, input logic eh, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v;  rs = a;  rs_used = au;  rt = b;  rt_used = bu;
    dest = d;  wr = w;  ld = l;  hlt = h;  br = bt;  wb_idx = wi;  wb_v = wv;
    e.nm = nm;  e.s = es;  e.f = ef;  e.h = eh;  e.e = ee;
    q.push_back(e);
  endtask

  // Asynchronous assertion mid-cycle; outputs must read zero while held.
  task automatic do_reset(input string nm);
    exp_t e;
    @(posedge clk);
    #3;
    rst = 1'b1;
    id_valid = 0; rs_used = 0; rt_used = 0; wr = 0; ld = 0; hlt = 0; br = 0; wb_v = 0;
    rs = '0; rt = '0; dest = '0; wb_idx = '0;
    e.nm = nm;  e.s = 0;  e.f = 0;  e.h = 0;  e.e = 0;
    q.push_back(e);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    do_reset("reset");
    //   name           v rs ru rt rtu d w l h br wi wv  s f h e
    step("lu_ld3",      1,0,0, 0,0, 3,1,1,0,0, 0,0, 0,0,0,0);
    step("lu_st1",      1,3,1, 0,0, 4,1,0,0,0, 0,0, 1,0,0,0);
    step("lu_st2",      1,3,1, 0,0, 4,1,0,0,0, 0,0, 1,0,0,0);
    step("lu_st3_wb",   1,3,1, 0,0, 4,1,0,0,0, 3,1, 1,0,0,0);
    step("lu_go",       1,3,1, 0,0, 4,1,0,0,0, 0,0, 0,0,0,0);
    step("wb_r4",       0,0,0, 0,0, 0,0,0,0,0, 4,1, 0,0,0,0);
    step("add_r2",      1,0,0, 0,0, 2,1,0,0,0, 0,0, 0,0,0,0);
    step("use_r2",      1,0,0, 2,1, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("wb_r2",       0,0,0, 0,0, 0,0,0,0,0, 2,1, 0,0,0,0);
    step("ld_r6",       1,0,0, 0,0, 6,1,1,0,0, 0,0, 0,0,0,0);
    step("rt_r6",       1,0,0, 6,1, 0,0,0,0,0, 0,0, 1,0,0,0);
    step("r6_unused",   1,6,0, 6,0, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("r6_invalid",  0,6,1, 6,1, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("wb_r6",       0,0,0, 0,0, 0,0,0,0,0, 6,1, 0,0,0,0);
    step("rt_r6_ok",    1,0,0, 6,1, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("add_r4",      1,0,0, 0,0, 4,1,0,0,0, 0,0, 0,0,0,0);
    step("ld_r4_wb",    1,0,0, 0,0, 4,1,1,0,0, 4,1, 0,0,0,0);
    step("use_r4",      1,4,1, 0,0, 0,0,0,0,0, 0,0, 1,0,0,0);
    step("use_r4_wb",   1,4,1, 0,0, 0,0,0,0,0, 4,1, 1,0,0,0);
    step("use_r4_ok",   1,4,1, 0,0, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("br_ld5",      1,0,0, 0,0, 5,1,1,0,1, 0,0, 0,1,0,0);
    step("use_r5",      1,5,1, 5,1, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("ld_r1",       1,0,0, 0,0, 1,1,1,0,0, 0,0, 0,0,0,0);
    step("br_ovr_stl",  1,1,1, 0,0, 0,0,0,0,1, 0,0, 0,1,0,0);
    step("halt_br",     1,0,0, 0,0, 0,0,0,1,1, 0,0, 0,1,0,0);
    step("still_run",   0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("halt",        1,0,0, 0,0, 0,0,0,1,0, 0,0, 0,0,0,0);
    step("dr_br",       0,0,0, 0,0, 0,0,0,0,1, 0,0, 1,0,0,0);
    step("dr_idle",     0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,0);
    step("dr_wb1",      0,0,0, 0,0, 0,0,0,0,0, 1,1, 1,0,0,0);
    step("dr_c1",       0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,0);
    step("dr_c2",       0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,0);
    step("halted",      0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,1,0);
    step("halted_br",   0,0,0, 0,0, 0,0,0,0,1, 0,0, 1,0,1,0);
    do_reset("rst_halted");
    step("w7a",         1,0,0, 0,0, 7,1,0,0,0, 0,0, 0,0,0,0);
    step("w7b",         1,0,0, 0,0, 7,1,0,0,0, 0,0, 0,0,0,0);
    step("w7c",         1,0,0, 0,0, 7,1,0,0,0, 0,0, 0,0,0,0);
    step("w7d_ovf",     1,0,0, 0,0, 7,1,0,0,0, 0,0, 0,0,0,0);
    step("err_on",      0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0,0,1);
    step("halt2",       1,0,0, 0,0, 0,0,0,1,0, 0,0, 0,0,0,1);
    step("d2_wb7a",     0,0,0, 0,0, 0,0,0,0,0, 7,1, 1,0,0,1);
    step("d2_wb7b",     0,0,0, 0,0, 0,0,0,0,0, 7,1, 1,0,0,1);
    step("d2_wb7c",     0,0,0, 0,0, 0,0,0,0,0, 7,1, 1,0,0,1);
    step("d2_c1",       0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,1);
    step("d2_c2",       0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,1);
    step("halted2",     0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,1,1);
    do_reset("rst_err");
    step("uf_wb0",      0,0,0, 0,0, 0,0,0,0,0, 0,1, 0,0,0,0);
    step("uf_err",      0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0,0,1);
    do_reset("rst_uf");
    step("ld_r2",       1,0,0, 0,0, 2,1,1,0,0, 0,0, 0,0,0,0);
    step("halt3",       1,0,0, 0,0, 0,0,0,1,0, 0,0, 0,0,0,0);
    step("d3",          0,0,0, 0,0, 0,0,0,0,0, 0,0, 1,0,0,0);
    do_reset("rst_drain");
    step("post_run",    0,0,0, 0,0, 0,0,0,0,0, 0,0, 0,0,0,0);
    step("post_r2",     1,2,1, 2,1, 0,0,0,0,0, 0,0, 0,0,0,0);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue got %0d pending exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
